// File: rtl/load_store_unit.sv
// Load/store sequencer between the EX stage and Data_Memory: legality check, one-cycle
// memory strobe, read-latency wait, load alignment/extension and a one-cycle response.
module load_store_unit #(
    parameter int XLEN       = 32,
    parameter int RD_LATENCY = 1
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_req_valid,
    output logic            o_req_ready,
    input  logic            i_req_is_store,
    input  logic [2:0]      i_req_funct3,
    input  logic [XLEN-1:0] i_req_addr,
    input  logic [XLEN-1:0] i_req_wdata,
    output logic            o_resp_valid,
    output logic            o_resp_error,
    output logic [XLEN-1:0] o_resp_rdata,
    output logic            o_mem_write_enable,
    output logic            o_mem_read_enable,
    output logic [XLEN-1:0] o_mem_address,
    output logic [XLEN-1:0] o_mem_write_data,
    output logic [3:0]      o_mem_byte_enable,
    input  logic [XLEN-1:0] i_mem_read_data
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WAIT   = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic            w_accept;
    logic            w_legal;
    logic [1:0]      r_off;
    logic [2:0]      r_funct3;
    logic            r_is_store;
    logic            r_err;
    logic [2:0]      r_cnt;
    logic [XLEN-1:0] r_load_data;

    function automatic logic f_legal(input logic is_store, input logic [2:0] f3,
                                     input logic [1:0] off);
        logic legal;
        case (f3)
            3'b000:  legal = 1'b1;
            3'b001:  legal = (off[0] == 1'b0);
            3'b010:  legal = (off == 2'b00);
            3'b100:  legal = !is_store;
            3'b101:  legal = !is_store && (off[0] == 1'b0);
            default: legal = 1'b0;
        endcase
        return legal;
    endfunction

    function automatic logic [3:0] f_byte_enable(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] be;
        case (size)
            2'b00:   be = 4'b0001 << off;
            2'b01:   be = 4'b0011 << off;
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    function automatic logic [XLEN-1:0] f_store_data(input logic [XLEN-1:0] wd,
                                                     input logic [1:0] size);
        logic [XLEN-1:0] d;
        case (size)
            2'b00:   d = {(XLEN/8){wd[7:0]}};
            2'b01:   d = {(XLEN/16){wd[15:0]}};
            default: d = wd;
        endcase
        return d;
    endfunction

    // Lane select by the latched byte offset, then sign/zero extend by funct3.
    function automatic logic [XLEN-1:0] f_load_extend(input logic [XLEN-1:0] rd,
                                                      input logic [2:0] f3,
                                                      input logic [1:0] off);
        logic [7:0]      b;
        logic [15:0]     h;
        logic [XLEN-1:0] d;
        b = rd[{off, 3'b000} +: 8];
        h = rd[{off[1], 4'b0000} +: 16];
        case (f3)
            3'b000:  d = {{(XLEN-8){b[7]}}, b};
            3'b100:  d = {{(XLEN-8){1'b0}}, b};
            3'b001:  d = {{(XLEN-16){h[15]}}, h};
            3'b101:  d = {{(XLEN-16){1'b0}}, h};
            default: d = rd;
        endcase
        return d;
    endfunction

    assign w_accept = (r_state == S_IDLE) && i_req_valid;
    assign w_legal  = f_legal(i_req_is_store, i_req_funct3, i_req_addr[1:0]);

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            o_req_ready <= 1'b1;
        end else begin
            r_state     <= w_next_state;
            o_req_ready <= (w_next_state == S_IDLE);
        end
    end

    // Next-state decode.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next_state = w_legal ? S_ACCESS : S_RESP;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_ACCESS: begin
                if (r_is_store) begin
                    w_next_state = S_RESP;
                end else begin
                    w_next_state = S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_cnt == 3'd0) begin
                    w_next_state = S_RESP;
                end else begin
                    w_next_state = S_WAIT;
                end
            end
            S_RESP:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Request capture on acceptance.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_off      <= 2'b00;
            r_funct3   <= 3'b000;
            r_is_store <= 1'b0;
            r_err      <= 1'b0;
        end else if (w_accept) begin
            r_off      <= i_req_addr[1:0];
            r_funct3   <= i_req_funct3;
            r_is_store <= i_req_is_store;
            r_err      <= !w_legal;
        end
    end

    // Memory strobe: registered so the enables coincide with ACCESS; address/data hold otherwise.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_mem_write_enable <= 1'b0;
            o_mem_read_enable  <= 1'b0;
            o_mem_address      <= '0;
            o_mem_write_data   <= '0;
            o_mem_byte_enable  <= 4'b0000;
        end else if (w_accept && w_legal) begin
            o_mem_write_enable <= i_req_is_store;
            o_mem_read_enable  <= !i_req_is_store;
            o_mem_address      <= {i_req_addr[XLEN-1:2], 2'b00};
            o_mem_write_data   <= f_store_data(i_req_wdata, i_req_funct3[1:0]);
            o_mem_byte_enable  <= f_byte_enable(i_req_funct3[1:0], i_req_addr[1:0]);
        end else begin
            o_mem_write_enable <= 1'b0;
            o_mem_read_enable  <= 1'b0;
        end
    end

    // Read-latency countdown and load data capture.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt       <= 3'd0;
            r_load_data <= '0;
        end else if (r_state == S_ACCESS) begin
            r_cnt <= 3'(RD_LATENCY - 1);
        end else if (r_state == S_WAIT) begin
            if (r_cnt == 3'd0) begin
                r_load_data <= f_load_extend(i_mem_read_data, r_funct3, r_off);
            end else begin
                r_cnt <= r_cnt - 3'd1;
            end
        end
    end

    // Response pulse; load data is published together with resp_valid.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_resp_valid <= 1'b0;
            o_resp_error <= 1'b0;
            o_resp_rdata <= '0;
        end else begin
            o_resp_valid <= (r_state == S_RESP);
            o_resp_error <= (r_state == S_RESP) && r_err;
            if ((r_state == S_RESP) && !r_err && !r_is_store) begin
                o_resp_rdata <= r_load_data;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: one instance with RD_LATENCY=1 and one with 3,
// behavioural memories with matching read latency, directed request vectors.
module tb_load_store_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        err;
        logic        chk_rd;
        logic [31:0] rdata;
        logic [31:0] cyc;
    } resp_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
    } mem_t;

    resp_t qa[$];
    resp_t qb[$];
    mem_t  ma[$];
    resp_t ea, eb;
    mem_t  em;
    int    errors = 0;
    int    checks = 0;
    int    cyc = 0;

    logic        a_rst = 1'b1, a_req_valid = 1'b0, a_req_is_store = 1'b0;
    logic [2:0]  a_req_funct3 = 3'b000;
    logic [31:0] a_req_addr = 32'h0, a_req_wdata = 32'h0, a_rd_word = 32'h0;
    logic        a_req_ready, a_resp_valid, a_resp_error, a_mem_write_enable, a_mem_read_enable;
    logic [31:0] a_resp_rdata, a_mem_address, a_mem_write_data, a_mem_read_data;
    logic [3:0]  a_mem_byte_enable;
    logic        a_vpipe = 1'b0;

    logic        b_rst = 1'b1, b_req_valid = 1'b0, b_req_is_store = 1'b0;
    logic [2:0]  b_req_funct3 = 3'b000;
    logic [31:0] b_req_addr = 32'h0, b_req_wdata = 32'h0, b_rd_word = 32'h0;
    logic        b_req_ready, b_resp_valid, b_resp_error, b_mem_write_enable, b_mem_read_enable;
    logic [31:0] b_resp_rdata, b_mem_address, b_mem_write_data, b_mem_read_data;
    logic [3:0]  b_mem_byte_enable;
    logic [2:0]  b_vpipe = 3'b000;

    load_store_unit #(.XLEN(32), .RD_LATENCY(1)) u_dut_a (
        .i_clk(clk), .i_rst(a_rst), .i_req_valid(a_req_valid), .o_req_ready(a_req_ready),
        .i_req_is_store(a_req_is_store), .i_req_funct3(a_req_funct3), .i_req_addr(a_req_addr),
        .i_req_wdata(a_req_wdata), .o_resp_valid(a_resp_valid), .o_resp_error(a_resp_error),
        .o_resp_rdata(a_resp_rdata), .o_mem_write_enable(a_mem_write_enable),
        .o_mem_read_enable(a_mem_read_enable), .o_mem_address(a_mem_address),
        .o_mem_write_data(a_mem_write_data), .o_mem_byte_enable(a_mem_byte_enable),
        .i_mem_read_data(a_mem_read_data)
    );

    load_store_unit #(.XLEN(32), .RD_LATENCY(3)) u_dut_b (
        .i_clk(clk), .i_rst(b_rst), .i_req_valid(b_req_valid), .o_req_ready(b_req_ready),
        .i_req_is_store(b_req_is_store), .i_req_funct3(b_req_funct3), .i_req_addr(b_req_addr),
        .i_req_wdata(b_req_wdata), .o_resp_valid(b_resp_valid), .o_resp_error(b_resp_error),
        .o_resp_rdata(b_resp_rdata), .o_mem_write_enable(b_mem_write_enable),
        .o_mem_read_enable(b_mem_read_enable), .o_mem_address(b_mem_address),
        .o_mem_write_data(b_mem_write_data), .o_mem_byte_enable(b_mem_byte_enable),
        .i_mem_read_data(b_mem_read_data)
    );

    // Memories return the word only in the single cycle RD_LATENCY after the read strobe.
    always @(posedge clk) begin
        cyc     <= cyc + 1;
        a_vpipe <= a_mem_read_enable;
        b_vpipe <= {b_vpipe[1:0], b_mem_read_enable};
    end
    assign a_mem_read_data = a_vpipe    ? a_rd_word : 32'h5A5A5A5A;
    assign b_mem_read_data = b_vpipe[2] ? b_rd_word : 32'h5A5A5A5A;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Response monitor, instance A, plus memory strobe checking.
    always @(negedge clk) begin
        if (a_resp_valid) begin
            if (qa.size() == 0) begin
                checks++; errors++;
                $display("FAIL a_unexpected_resp: actual=resp_valid expected=idle");
            end else begin
                ea = qa.pop_front();
                chk("a_resp_error", {31'b0, a_resp_error}, {31'b0, ea.err});
                chk("a_resp_cycle", cyc, ea.cyc);
                if (ea.chk_rd) chk("a_resp_rdata", a_resp_rdata, ea.rdata);
            end
        end
        if (a_mem_write_enable || a_mem_read_enable) begin
            if (ma.size() == 0) begin
                checks++; errors++;
                $display("FAIL a_unexpected_mem: actual we=%b re=%b expected none",
                         a_mem_write_enable, a_mem_read_enable);
            end else begin
                em = ma.pop_front();
                chk("a_mem_we", {31'b0, a_mem_write_enable}, {31'b0, em.we});
                chk("a_mem_re", {31'b0, a_mem_read_enable}, {31'b0, !em.we});
                chk("a_mem_addr", a_mem_address, em.addr);
                chk("a_mem_be", {28'b0, a_mem_byte_enable}, {28'b0, em.be});
                if (em.we) chk("a_mem_wd", a_mem_write_data, em.wd);
            end
        end
    end

    // Response monitor, instance B.
    always @(negedge clk) begin
        if (b_resp_valid) begin
            if (qb.size() == 0) begin
                checks++; errors++;
                $display("FAIL b_unexpected_resp: actual=resp_valid expected=idle");
            end else begin
                eb = qb.pop_front();
                chk("b_resp_error", {31'b0, b_resp_error}, {31'b0, eb.err});
                chk("b_resp_cycle", cyc, eb.cyc);
                if (eb.chk_rd) chk("b_resp_rdata", b_resp_rdata, eb.rdata);
            end
        end
    end

    // Called at a negedge; waits for ready, presents the request for one accept edge.
    task automatic issue(input bit d, input logic st, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rdw,
                         input logic exp_err, input logic [31:0] exp_rd, input logic chk_rd,
                         input int lat, input bit hold, input logic [31:0] m_addr,
                         input logic [3:0] m_be, input logic [31:0] m_wd);
        int n;
        n = 0;
        while (!(d ? b_req_ready : a_req_ready) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++; errors++;
            $display("FAIL req_ready_timeout: actual=0 expected=1");
            a_req_valid = 1'b0;
            b_req_valid = 1'b0;
            return;
        end
        if (d) begin
            b_req_is_store = st; b_req_funct3 = f3; b_req_addr = addr; b_req_wdata = wd;
            b_rd_word = rdw; b_req_valid = 1'b1;
            qb.push_back('{exp_err, chk_rd, exp_rd, 32'(cyc + 1 + lat)});
        end else begin
            a_req_is_store = st; a_req_funct3 = f3; a_req_addr = addr; a_req_wdata = wd;
            a_rd_word = rdw; a_req_valid = 1'b1;
            qa.push_back('{exp_err, chk_rd, exp_rd, 32'(cyc + 1 + lat)});
            if (!exp_err) ma.push_back('{st, m_addr, m_be, m_wd});
        end
        @(negedge clk);
        if (!hold) begin
            a_req_valid = 1'b0;
            b_req_valid = 1'b0;
        end
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        chk("rst_req_ready", {31'b0, a_req_ready}, 32'd1);
        chk("rst_resp_valid", {31'b0, a_resp_valid}, 32'd0);
        chk("rst_resp_error", {31'b0, a_resp_error}, 32'd0);
        chk("rst_mem_we", {31'b0, a_mem_write_enable}, 32'd0);
        chk("rst_mem_re", {31'b0, a_mem_read_enable}, 32'd0);
        chk("rst_mem_be", {28'b0, a_mem_byte_enable}, 32'd0);
        chk("rst_mem_addr", a_mem_address, 32'd0);
        chk("rst_mem_wd", a_mem_write_data, 32'd0);
        chk("rst_resp_rdata", a_resp_rdata, 32'd0);
        a_rst = 1'b0;
        b_rst = 1'b0;
        @(negedge clk);

        //      d  st  f3      addr   wdata         rdword        err  exp_rd        chk lat hold m_addr  be       m_wd
        issue(0, 1, 3'b010, 32'h0C, 32'hDEADBEEF, 32'h0,        0, 32'h0,        0, 2, 0, 32'h0C, 4'b1111, 32'hDEADBEEF);
        issue(0, 1, 3'b000, 32'h03, 32'h000000A5, 32'h0,        0, 32'h0,        0, 2, 0, 32'h00, 4'b1000, 32'hA5A5A5A5);
        issue(0, 0, 3'b000, 32'h03, 32'h0,        32'hA5000000, 0, 32'hFFFFFFA5, 1, 3, 0, 32'h00, 4'b1000, 32'h0);
        issue(0, 0, 3'b100, 32'h03, 32'h0,        32'hA5000000, 0, 32'h000000A5, 1, 3, 0, 32'h00, 4'b1000, 32'h0);
        issue(0, 0, 3'b001, 32'h02, 32'h0,        32'h80010000, 0, 32'hFFFF8001, 1, 3, 0, 32'h00, 4'b1100, 32'h0);
        issue(0, 0, 3'b101, 32'h02, 32'h0,        32'h80010000, 0, 32'h00008001, 1, 3, 0, 32'h00, 4'b1100, 32'h0);
        issue(0, 0, 3'b010, 32'h08, 32'h0,        32'h12345678, 0, 32'h12345678, 1, 3, 0, 32'h08, 4'b1111, 32'h0);
        issue(0, 0, 3'b000, 32'h11, 32'h0,        32'h00007F00, 0, 32'h0000007F, 1, 3, 0, 32'h10, 4'b0010, 32'h0);
        issue(0, 1, 3'b001, 32'h02, 32'h00001234, 32'h0,        0, 32'h0,        0, 2, 0, 32'h00, 4'b1100, 32'h12341234);
        // Illegal requests: no strobe, rdata keeps the last load value.
        issue(0, 0, 3'b010, 32'h06, 32'h0,        32'h0,        1, 32'h0000007F, 1, 1, 0, 32'h0,  4'b0000, 32'h0);
        issue(0, 1, 3'b001, 32'h01, 32'h0000FFFF, 32'h0,        1, 32'h0000007F, 1, 1, 0, 32'h0,  4'b0000, 32'h0);
        issue(0, 0, 3'b011, 32'h00, 32'h0,        32'h0,        1, 32'h0000007F, 1, 1, 0, 32'h0,  4'b0000, 32'h0);
        issue(0, 1, 3'b100, 32'h00, 32'h0,        32'h0,        1, 32'h0000007F, 1, 1, 0, 32'h0,  4'b0000, 32'h0);
        issue(0, 0, 3'b101, 32'h01, 32'h0,        32'h0,        1, 32'h0000007F, 1, 1, 0, 32'h0,  4'b0000, 32'h0);
        // Back-to-back stores with req_valid held high.
        issue(0, 1, 3'b010, 32'h20, 32'h11111111, 32'h0,        0, 32'h0,        0, 2, 1, 32'h20, 4'b1111, 32'h11111111);
        issue(0, 1, 3'b000, 32'h21, 32'h00000022, 32'h0,        0, 32'h0,        0, 2, 1, 32'h20, 4'b0010, 32'h22222222);
        issue(0, 1, 3'b001, 32'h22, 32'h00003333, 32'h0,        0, 32'h0,        0, 2, 0, 32'h20, 4'b1100, 32'h33333333);
        // Three-cycle read latency.
        issue(1, 0, 3'b001, 32'h02, 32'h0,        32'h80010000, 0, 32'hFFFF8001, 1, 5, 0, 32'h0,  4'b0000, 32'h0);
        issue(1, 0, 3'b101, 32'h02, 32'h0,        32'h80010000, 0, 32'h00008001, 1, 5, 0, 32'h0,  4'b0000, 32'h0);

        // Reset during WAIT of a word load: no response may follow.
        while (!b_req_ready) @(negedge clk);
        b_req_is_store = 1'b0; b_req_funct3 = 3'b010; b_req_addr = 32'h04; b_rd_word = 32'h0BADF00D;
        b_req_valid = 1'b1;
        @(negedge clk);
        b_req_valid = 1'b0;
        @(negedge clk);
        b_rst = 1'b1;
        @(negedge clk);
        chk("b_rst_req_ready", {31'b0, b_req_ready}, 32'd1);
        chk("b_rst_mem_re", {31'b0, b_mem_read_enable}, 32'd0);
        chk("b_rst_resp_valid", {31'b0, b_resp_valid}, 32'd0);
        chk("b_rst_resp_rdata", b_resp_rdata, 32'd0);
        b_rst = 1'b0;
        repeat (8) @(negedge clk);
        issue(1, 0, 3'b010, 32'h04, 32'h0,        32'hCAFEF00D, 0, 32'hCAFEF00D, 1, 5, 0, 32'h0,  4'b0000, 32'h0);

        repeat (10) @(negedge clk);
        chk("a_resp_drained", 32'(qa.size()), 32'd0);
        chk("b_resp_drained", 32'(qb.size()), 32'd0);
        chk("a_mem_drained", 32'(ma.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
